// File: rtl/cmp_pkg.sv
// Shared encodings for the nibble-serial word comparator.
//   ST_COLLECT / ST_HOLD : FSM state encoding
//   CMP_LT / CMP_EQ / CMP_GT : word-level verdict encoding
//   onehot3()            : true when exactly one of three flags is set
package cmp_pkg;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_HOLD    = 1'b1;

    localparam logic [1:0] CMP_LT = 2'd0;
    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    typedef enum logic {
        S_COLLECT = ST_COLLECT,
        S_HOLD    = ST_HOLD
    } state_e;

    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
    endfunction

endpackage

// File: rtl/nibble_serial_compare_fsm.sv
// Folds per-nibble gt/eq/lt flags of a word pair, streamed MSB nibble first,
// into one word-level verdict; the first non-equal nibble decides it.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   nib_valid/nib_ready           nibble handshake
//   nib_gt/nib_eq/nib_lt          per-nibble comparator flags
//   nib_last                      nibble is the LSB nibble of the word
//   res_valid/res_ready           verdict handshake
//   res_gt/res_eq/res_lt          word verdict (exactly one set while valid)
//   res_err                       flag fault or forced termination at MAX_NIBBLES
//   res_cnt                       nibbles consumed for the word
module nibble_serial_compare_fsm
    import cmp_pkg::*;
#(
    parameter int MAX_NIBBLES = 8,
    parameter int CNT_W       = $clog2(MAX_NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nib_valid,
    input  logic             nib_gt,
    input  logic             nib_eq,
    input  logic             nib_lt,
    input  logic             nib_last,
    output logic             nib_ready,
    output logic             res_valid,
    output logic             res_gt,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_err,
    output logic [CNT_W-1:0] res_cnt,
    input  logic             res_ready
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               decided_q, decided_d;
    logic [1:0]         dir_q, dir_d;
    logic               err_q, err_d;
    logic               res_gt_q, res_eq_q, res_lt_q, res_err_q;
    logic [CNT_W-1:0]   res_cnt_q;

    logic               beat, flags_ok, take_dir, at_max, term;
    logic [1:0]         verdict_d;

    // Per-beat accumulation; only committed when a beat actually happens.
    always_comb begin
        beat      = nib_valid && (state_q == S_COLLECT);
        flags_ok  = onehot3(nib_gt, nib_eq, nib_lt);
        cnt_d     = cnt_q + 1'b1;
        // A faulty beat never decides, even if gt or lt is among its flags.
        take_dir  = !decided_q && flags_ok && (nib_gt || nib_lt);
        decided_d = decided_q || take_dir;
        dir_d     = take_dir ? (nib_gt ? CMP_GT : CMP_LT) : dir_q;
        at_max    = (cnt_d == CNT_W'(MAX_NIBBLES));
        term      = nib_last || at_max;
        err_d     = err_q || !flags_ok || (at_max && !nib_last);
        verdict_d = decided_d ? dir_d : CMP_EQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_COLLECT;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            dir_q     <= CMP_LT;
            err_q     <= 1'b0;
            res_gt_q  <= 1'b0;
            res_eq_q  <= 1'b0;
            res_lt_q  <= 1'b0;
            res_err_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (beat) begin
                        cnt_q     <= cnt_d;
                        decided_q <= decided_d;
                        dir_q     <= dir_d;
                        err_q     <= err_d;
                        if (term) begin
                            state_q   <= S_HOLD;
                            res_gt_q  <= (verdict_d == CMP_GT);
                            res_eq_q  <= (verdict_d == CMP_EQ);
                            res_lt_q  <= (verdict_d == CMP_LT);
                            res_err_q <= err_d;
                            res_cnt_q <= cnt_d;
                        end
                    end
                end
                S_HOLD: begin
                    // Result fields are left as-is; only the word accumulators clear.
                    if (res_ready) begin
                        state_q   <= S_COLLECT;
                        cnt_q     <= '0;
                        decided_q <= 1'b0;
                        dir_q     <= CMP_LT;
                        err_q     <= 1'b0;
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

    assign nib_ready = (state_q == S_COLLECT);
    assign res_valid = (state_q == S_HOLD);
    assign res_gt    = res_gt_q;
    assign res_eq    = res_eq_q;
    assign res_lt    = res_lt_q;
    assign res_err   = res_err_q;
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_nibble_serial_compare_fsm.sv
module tb_nibble_serial_compare_fsm;

    localparam int MAXN = 8;
    localparam int CW   = $clog2(MAXN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          nib_valid, nib_gt, nib_eq, nib_lt, nib_last;
    logic          nib_ready, res_valid, res_gt, res_eq, res_lt, res_err;
    logic [CW-1:0] res_cnt;
    logic          res_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // {nib_ready, res_valid, res_gt, res_eq, res_lt, res_err, res_cnt}
    logic [5+CW:0] obs;
    assign obs = {nib_ready, res_valid, res_gt, res_eq, res_lt, res_err, res_cnt};

    always #5 clk = ~clk;

    nibble_serial_compare_fsm #(.MAX_NIBBLES(MAXN)) dut (
        .clk(clk), .rst(rst),
        .nib_valid(nib_valid), .nib_gt(nib_gt), .nib_eq(nib_eq), .nib_lt(nib_lt),
        .nib_last(nib_last), .nib_ready(nib_ready),
        .res_valid(res_valid), .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt),
        .res_err(res_err), .res_cnt(res_cnt), .res_ready(res_ready)
    );

    // Inputs change #1 after a rising edge; outputs are read at the same point.
    task automatic set_nib(input logic v, input logic g, input logic e, input logic l, input logic last);
        nib_valid = v; nib_gt = g; nib_eq = e; nib_lt = l; nib_last = last;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic g, input logic e, input logic l, input logic last);
        set_nib(1'b1, g, e, l, last);
        tick();
        set_nib(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_result(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if (obs[5+CW:4+CW] !== 2'b10)
            $display("FAIL %s_release got rdy/vld=%b want 10", name, obs[5+CW:4+CW]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; res_ready = 1'b0;
        set_nib(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        rst = 1'b0;
        set_nib(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {6'b100000, 4'd0}) $display("FAIL reset got %b want %b", obs, {6'b100000, 4'd0});
        else n_pass++;
    endtask

    task automatic test_gt_word();
        beat(0, 1, 0, 0);
        beat(0, 1, 0, 0);
        n_checks++;
        if (obs !== {6'b100000, 4'd0}) $display("FAIL gt_midword got %b want %b", obs, {6'b100000, 4'd0});
        else n_pass++;
        beat(1, 0, 0, 1);
        n_checks++;
        if (obs !== {6'b011000, 4'd3}) $display("FAIL gt_verdict got %b want %b", obs, {6'b011000, 4'd3});
        else n_pass++;
        release_result("gt");
    endtask

    task automatic test_lt_word();
        beat(0, 0, 1, 0);
        // idle cycle carrying garbage flags must be ignored
        set_nib(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        beat(0, 0, 1, 1);
        n_checks++;
        if (obs !== {6'b010010, 4'd2}) $display("FAIL lt_verdict got %b want %b", obs, {6'b010010, 4'd2});
        else n_pass++;
        release_result("lt");
    endtask

    task automatic test_eq_word();
        for (int i = 0; i < 3; i++) beat(0, 1, 0, 0);
        n_checks++;
        if (obs[5+CW:4+CW] !== 2'b10) $display("FAIL eq_midword got rdy/vld=%b want 10", obs[5+CW:4+CW]);
        else n_pass++;
        beat(0, 1, 0, 1);
        n_checks++;
        if (obs !== {6'b010100, 4'd4}) $display("FAIL eq_verdict got %b want %b", obs, {6'b010100, 4'd4});
        else n_pass++;
        release_result("eq");
    endtask

    task automatic test_backpressure();
        beat(1, 0, 0, 1);
        n_checks++;
        if (obs !== {6'b011000, 4'd1}) $display("FAIL bp_verdict got %b want %b", obs, {6'b011000, 4'd1});
        else n_pass++;
        set_nib(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== {6'b011000, 4'd1}) $display("FAIL bp_hold%0d got %b want %b", i, obs, {6'b011000, 4'd1});
            else n_pass++;
        end
        // nibble still offered during the consume cycle: must not be taken there
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if (obs[5+CW:4+CW] !== 2'b10) $display("FAIL bp_consume got rdy/vld=%b want 10", obs[5+CW:4+CW]);
        else n_pass++;
        tick();
        set_nib(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {6'b010010, 4'd1}) $display("FAIL bp_next_word got %b want %b", obs, {6'b010010, 4'd1});
        else n_pass++;
        release_result("bp");
    endtask

    task automatic test_flag_fault();
        beat(1, 0, 1, 0);
        beat(0, 1, 0, 1);
        n_checks++;
        if (obs !== {6'b010101, 4'd2}) $display("FAIL fault_verdict got %b want %b", obs, {6'b010101, 4'd2});
        else n_pass++;
        release_result("fault");
    endtask

    task automatic test_overflow_and_reset();
        for (int i = 0; i < MAXN; i++) beat(0, 1, 0, 0);
        n_checks++;
        if (obs !== {6'b010101, 4'd8}) $display("FAIL ovf_verdict got %b want %b", obs, {6'b010101, 4'd8});
        else n_pass++;
        // ninth nibble offered while holding: not consumed
        set_nib(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_nib(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {6'b010101, 4'd8}) $display("FAIL ovf_hold got %b want %b", obs, {6'b010101, 4'd8});
        else n_pass++;
        release_result("ovf");
        // ninth nibble starts a fresh word with err cleared
        beat(0, 1, 0, 1);
        n_checks++;
        if (obs !== {6'b010100, 4'd1}) $display("FAIL ovf_newword got %b want %b", obs, {6'b010100, 4'd1});
        else n_pass++;
        release_result("ovf2");
        // reset in the middle of a 2-nibble word
        beat(1, 0, 0, 0);
        rst = 1'b1;
        set_nib(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        set_nib(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {6'b100000, 4'd0}) $display("FAIL midreset got %b want %b", obs, {6'b100000, 4'd0});
        else n_pass++;
        tick();
        n_checks++;
        if (obs !== {6'b100000, 4'd0}) $display("FAIL midreset_idle got %b want %b", obs, {6'b100000, 4'd0});
        else n_pass++;
        beat(0, 1, 0, 1);
        n_checks++;
        if (obs !== {6'b010100, 4'd1}) $display("FAIL postreset_word got %b want %b", obs, {6'b010100, 4'd1});
        else n_pass++;
        release_result("postreset");
    endtask

    initial begin
        set_nib(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; res_ready = 1'b0;
        #1;
        test_reset();
        test_gt_word();
        test_lt_word();
        test_eq_word();
        test_backpressure();
        test_flag_fault();
        test_overflow_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
